timer6_ctrl: RTL and testbench

Front-panel controller for the `timer6` countdown datapath. It synchronizes and debounces the five raw push-buttons and turns them into single-cycle press events. It sequences the timer through edit, run, pause and alarm modes, and drives the datapath's cursor and digit increment/decrement commands plus its count enable. It sits between the board buttons and `timer6`, which keeps the digit registers and reports `zero_i`/`done_i` back.

---
 rtl/timer6_ctrl.sv | 167 ++++++++++++++++
 tb/tb_timer6_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer6_ctrl.sv
// rtl/timer6_ctrl.sv - front-panel button conditioning and mode sequencing for timer6
//
// Ports:
//   clk_i, reset_i                       clock, synchronous active-high reset
//   start_i, left_i, right_i, up_i, down_i raw asynchronous buttons (active-high, bouncy)
//   zero_i                               programmed time is all zeros
//   done_i                               countdown reached zero (may be one cycle)
//   run_o                                count enable to the datapath
//   inc_o, dec_o                         one-cycle digit increment/decrement at digitp_o
//   digitp_o                             cursor position 0..5 (sec ones .. hour tens)
//   mode_o                               0 EDIT, 1 RUN, 2 PAUSE, 3 ALARM
//   alarm_o                              high while in ALARM
module timer6_ctrl #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned ALARM_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       zero_i,
  input  logic       done_i,
  output logic       run_o,
  output logic       inc_o,
  output logic       dec_o,
  output logic [2:0] digitp_o,
  output logic [1:0] mode_o,
  output logic       alarm_o
);

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  // Counter values at which the *next* edge completes the interval.
  localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYCLES - 1);
  localparam logic [15:0] ALARM_LAST = 16'(ALARM_CYCLES - 1);

  // Bit order: 4 start, 3 left, 2 right, 1 up, 0 down (also the priority order).
  logic [4:0] raw;
  logic [4:0] s1, s2, deb, deb_prev;
  logic [7:0] deb_cnt [5];
  logic [4:0] press;

  assign raw = {start_i, left_i, right_i, up_i, down_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1       <= '0;
      s2       <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      deb_prev <= deb;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign press = deb & ~deb_prev;

  // Only the highest-priority press of a cycle survives; the rest are dropped.
  logic p_start, p_left, p_right, p_up, p_down, any_press;

  always_comb begin
    p_start = 1'b0;
    p_left  = 1'b0;
    p_right = 1'b0;
    p_up    = 1'b0;
    p_down  = 1'b0;
    if (press[4])      p_start = 1'b1;
    else if (press[3]) p_left  = 1'b1;
    else if (press[2]) p_right = 1'b1;
    else if (press[1]) p_up    = 1'b1;
    else if (press[0]) p_down  = 1'b1;
    any_press = |press;
  end

  state_t      state;
  logic [15:0] alarm_cnt;

  assign mode_o = state;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= EDIT;
      digitp_o  <= 3'd0;
      run_o     <= 1'b0;
      inc_o     <= 1'b0;
      dec_o     <= 1'b0;
      alarm_o   <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      inc_o <= 1'b0;
      dec_o <= 1'b0;
      case (state)
        EDIT: begin
          if (p_start) begin
            if (!zero_i) begin
              state <= RUN;
              run_o <= 1'b1;
            end
          end else if (p_left) begin
            digitp_o <= (digitp_o == 3'd5) ? 3'd0 : digitp_o + 3'd1;
          end else if (p_right) begin
            digitp_o <= (digitp_o == 3'd0) ? 3'd5 : digitp_o - 3'd1;
          end else if (p_up) begin
            inc_o <= 1'b1;
          end else if (p_down) begin
            dec_o <= 1'b1;
          end
        end
        RUN: begin
          // done_i outranks a simultaneous start press.
          if (done_i) begin
            state     <= ALARM;
            run_o     <= 1'b0;
            alarm_o   <= 1'b1;
            alarm_cnt <= '0;
          end else if (p_start) begin
            state <= PAUSE;
            run_o <= 1'b0;
          end
        end
        PAUSE: begin
          if (p_start) begin
            state <= RUN;
            run_o <= 1'b1;
          end else if (p_down) begin
            state <= EDIT;
          end
        end
        ALARM: begin
          // Any press only acknowledges the alarm; it has no editing effect.
          if (any_press || alarm_cnt == ALARM_LAST) begin
            state     <= EDIT;
            alarm_o   <= 1'b0;
            alarm_cnt <= '0;
          end else begin
            alarm_cnt <= alarm_cnt + 16'd1;
          end
        end
        default: begin
          state <= EDIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer6_ctrl.sv
// tb/tb_timer6_ctrl.sv - table-driven bench for timer6_ctrl
module tb_timer6_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i, start_i, left_i, right_i, up_i, down_i, zero_i, done_i;
  logic       run_o, inc_o, dec_o, alarm_o;
  logic [2:0] digitp_o;
  logic [1:0] mode_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] B_START = 5'b10000;
  localparam logic [4:0] B_LEFT  = 5'b01000;
  localparam logic [4:0] B_RIGHT = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  timer6_ctrl #(.DEB_CYCLES(4), .ALARM_CYCLES(8)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .left_i   (left_i),
    .right_i  (right_i),
    .up_i     (up_i),
    .down_i   (down_i),
    .zero_i   (zero_i),
    .done_i   (done_i),
    .run_o    (run_o),
    .inc_o    (inc_o),
    .dec_o    (dec_o),
    .digitp_o (digitp_o),
    .mode_o   (mode_o),
    .alarm_o  (alarm_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [4:0] btn;
    logic       zero;
    logic [1:0] mode;
    logic [2:0] dp;
    logic       run;
    logic       inc;
    logic       dec;
  } vec_t;

  function automatic vec_t mk(logic [4:0] btn, logic zero, logic [1:0] mode,
                              logic [2:0] dp, logic run, logic inc, logic dec);
    vec_t v;
    v.btn = btn; v.zero = zero; v.mode = mode; v.dp = dp;
    v.run = run; v.inc = inc; v.dec = dec;
    return v;
  endfunction

  function automatic logic [15:0] obs();
    return {7'd0, mode_o, digitp_o, run_o, inc_o, dec_o, alarm_o};
  endfunction

  function automatic logic [15:0] exp_obs(logic [1:0] mode, logic [2:0] dp, logic run,
                                          logic inc, logic dec, logic alarm);
    return {7'd0, mode, dp, run, inc, dec, alarm};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] m);
    {start_i, left_i, right_i, up_i, down_i} = m;
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Raw-high from edge k; FSM acts at edge k+6; sample right after it.
  task automatic press(input logic [4:0] m);
    set_btn(m);
    step(7);
  endtask

  task automatic release_all();
    set_btn(5'b0);
    step(8);
  endtask

  task automatic count_inc(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (inc_o) cnt++;
    end
  endtask

  vec_t tv [22];
  int   n;

  initial begin
    tv[0]  = mk(B_LEFT,          1'b1, 2'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    tv[1]  = mk(B_LEFT,          1'b1, 2'd0, 3'd2, 1'b0, 1'b0, 1'b0);
    tv[2]  = mk(B_LEFT,          1'b1, 2'd0, 3'd3, 1'b0, 1'b0, 1'b0);
    tv[3]  = mk(B_LEFT,          1'b1, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[4]  = mk(B_LEFT,          1'b1, 2'd0, 3'd5, 1'b0, 1'b0, 1'b0);
    tv[5]  = mk(B_UP,            1'b1, 2'd0, 3'd5, 1'b0, 1'b1, 1'b0);
    tv[6]  = mk(B_LEFT,          1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tv[7]  = mk(B_RIGHT,         1'b1, 2'd0, 3'd5, 1'b0, 1'b0, 1'b0);
    tv[8]  = mk(B_DOWN,          1'b1, 2'd0, 3'd5, 1'b0, 1'b0, 1'b1);
    tv[9]  = mk(B_RIGHT,         1'b1, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[10] = mk(B_START,         1'b1, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[11] = mk(B_START,         1'b0, 2'd1, 3'd4, 1'b1, 1'b0, 1'b0);
    tv[12] = mk(B_UP,            1'b0, 2'd1, 3'd4, 1'b1, 1'b0, 1'b0);
    tv[13] = mk(B_START,         1'b0, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[14] = mk(B_UP,            1'b0, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[15] = mk(B_LEFT,          1'b0, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[16] = mk(B_START,         1'b0, 2'd1, 3'd4, 1'b1, 1'b0, 1'b0);
    tv[17] = mk(B_START,         1'b0, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[18] = mk(B_DOWN,          1'b0, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[19] = mk(B_START | B_UP,  1'b0, 2'd1, 3'd4, 1'b1, 1'b0, 1'b0);
    tv[20] = mk(B_START,         1'b0, 2'd2, 3'd4, 1'b0, 1'b0, 1'b0);
    tv[21] = mk(B_DOWN,          1'b0, 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);

    reset_i = 1'b1; zero_i = 1'b1; done_i = 1'b0;
    set_btn(5'b0);
    step(2);
    chk("reset_state", obs(), 16'd0);
    reset_i = 1'b0;
    step(2);
    chk("after_reset_idle", obs(), 16'd0);

    // Button held through reset: one press after re-debounce.
    set_btn(B_UP);
    reset_i = 1'b1;
    step(2);
    chk("reset_held_up", obs(), 16'd0);
    reset_i = 1'b0;
    step(6);
    chk("held_up_no_early_inc", {15'd0, inc_o}, 16'd0);
    step(1);
    chk("held_up_inc", obs(), exp_obs(2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    set_btn(5'b0);
    count_inc(12, n);
    chk("held_up_single_inc", 16'(n), 16'd0);

    // Bounce shorter than the debounce window.
    set_btn(B_UP);   step(2);
    set_btn(5'b0);   step(1);
    set_btn(B_UP);   step(2);
    set_btn(5'b0);
    count_inc(12, n);
    chk("glitch_no_inc", 16'(n), 16'd0);

    // Down held 6 cycles: dec in the cycle after edge k+6, for one cycle.
    set_btn(B_DOWN);
    step(6);
    set_btn(5'b0);
    chk("down_no_early_dec", {15'd0, dec_o}, 16'd0);
    step(1);
    chk("down_dec", obs(), exp_obs(2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    step(1);
    chk("down_dec_one_cycle", {15'd0, dec_o}, 16'd0);
    step(8);

    for (int i = 0; i < 22; i++) begin
      zero_i = tv[i].zero;
      press(tv[i].btn);
      chk($sformatf("vec%0d", i), obs(),
          exp_obs(tv[i].mode, tv[i].dp, tv[i].run, tv[i].inc, tv[i].dec, 1'b0));
      release_all();
      chk($sformatf("vec%0d_idle", i), {14'd0, inc_o, dec_o}, 16'd0);
    end

    // Alarm runs its full length.
    press(B_START);
    chk("alarm1_run", obs(), exp_obs(2'd1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    release_all();
    done_i = 1'b1;
    step(1);
    done_i = 1'b0;
    chk("alarm1_entry", obs(), exp_obs(2'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1));
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (!alarm_o) break;
      n++;
    end
    chk("alarm1_length", 16'(n), 16'd8);
    chk("alarm1_exit", obs(), exp_obs(2'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0));

    // Press during alarm exits early without editing.
    press(B_START);
    release_all();
    done_i = 1'b1;
    step(1);
    done_i = 1'b0;
    set_btn(B_UP);
    step(6);
    chk("alarm2_still_alarm", {14'd0, mode_o}, 16'd3);
    step(1);
    chk("alarm2_press_exit", obs(), exp_obs(2'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    set_btn(5'b0);
    count_inc(12, n);
    chk("alarm2_no_inc", 16'(n), 16'd0);

    // done_i and start press on the same edge in RUN.
    press(B_START);
    release_all();
    set_btn(B_START);
    step(6);
    done_i = 1'b1;
    step(1);
    done_i = 1'b0;
    set_btn(5'b0);
    chk("done_beats_start", obs(), exp_obs(2'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1));
    step(12);
    chk("done_start_back_edit", {14'd0, mode_o}, 16'd0);

    // Reset while running.
    press(B_LEFT);
    chk("pre_reset_cursor", {13'd0, digitp_o}, 16'd5);
    release_all();
    press(B_START);
    chk("pre_reset_run", obs(), exp_obs(2'd1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    release_all();
    reset_i = 1'b1;
    step(1);
    chk("reset_in_run", obs(), 16'd0);
    reset_i = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
